data_bus_responder: RTL

//  Memory-side responder for the CPU data-memory port (ce/we/addr/sel/data).

---
 rtl/data_bus_responder_if.sv | 21 ++
 rtl/data_bus_responder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/data_bus_responder_if.sv
// Data-memory port between the CPU data side and the memory responder.
// One request per cycle with a registered single-cycle ack.
interface data_bus_responder_if;
   logic        ce_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [3:0]  sel_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        ack_o;

   modport master (
      output ce_i, we_i, addr_i, sel_i, data_i,
      input  data_o, ack_o
   );

   modport slave (
      input  ce_i, we_i, addr_i, sel_i, data_i,
      output data_o, ack_o
   );
endinterface

// File: rtl/data_bus_responder.sv
// Memory-side responder: byte-lane-writable word RAM plus an MMIO window
// with a GPIO register pair and a free-running compare timer with interrupt.
module data_bus_responder #(
   parameter int         RAM_AW   = 10,
   parameter logic [3:0] MMIO_TAG = 4'h1,
   parameter int         GPIO_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   data_bus_responder_if.slave bus,
   output logic [GPIO_W-1:0] gpio_o,
   input  logic [GPIO_W-1:0] gpio_i,
   output logic              irq_o
);

   logic [31:0]       mem [2**RAM_AW];
   logic [RAM_AW-1:0] ram_idx;
   logic              is_mmio;
   logic [5:0]        reg_idx;
   logic              ram_wr;
   logic              mmio_wr;

   logic [GPIO_W-1:0] gpio_out;
   logic [GPIO_W-1:0] gpio_sync1;
   logic [GPIO_W-1:0] gpio_sync2;
   logic [31:0]       count;
   logic [31:0]       cmp;
   logic              enable;
   logic              pending;
   logic              match;
   logic              pending_clr;
   logic [31:0]       mmio_rdata;
   logic              unused;

   // Replace only the byte lanes whose enable is set.
   function automatic logic [31:0] merge(input logic [31:0] old_word,
                                         input logic [31:0] new_word,
                                         input logic [3:0]  lanes);
      logic [31:0] result;
      result = old_word;
      for (int k = 0; k < 4; k++) begin
         if (lanes[k]) result[8*k +: 8] = new_word[8*k +: 8];
      end
      return result;
   endfunction

   assign is_mmio     = (bus.addr_i[31:28] == MMIO_TAG);
   assign reg_idx     = bus.addr_i[7:2];
   assign ram_idx     = bus.addr_i[RAM_AW+1:2];
   assign ram_wr      = bus.ce_i && bus.we_i && !is_mmio;
   assign mmio_wr     = bus.ce_i && bus.we_i && is_mmio;
   assign match       = enable && (count == cmp);
   assign pending_clr = mmio_wr && (reg_idx == 6'h04) && bus.sel_i[0] && bus.data_i[1];
   assign unused      = ^{bus.addr_i[27:RAM_AW+2], bus.addr_i[1:0]};

   // RAM contents survive reset; a write arriving during reset is dropped.
   always_ff @(posedge clk) begin
      if (ram_wr && !rst) begin
         for (int k = 0; k < 4; k++) begin
            if (bus.sel_i[k]) mem[ram_idx][8*k +: 8] <= bus.data_i[8*k +: 8];
         end
      end
   end

   always_comb begin
      mmio_rdata = '0;
      case (reg_idx)
         6'h00:   mmio_rdata = {{(32-GPIO_W){1'b0}}, gpio_out};
         6'h01:   mmio_rdata = {{(32-GPIO_W){1'b0}}, gpio_sync2};
         6'h02:   mmio_rdata = count;
         6'h03:   mmio_rdata = cmp;
         6'h04:   mmio_rdata = {30'd0, pending, enable};
         default: mmio_rdata = '0;
      endcase
   end

   // Reads return the registered word; writes and idle cycles hold data_o.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.ack_o  <= 1'b0;
         bus.data_o <= '0;
      end else begin
         bus.ack_o <= bus.ce_i;
         if (bus.ce_i && !bus.we_i) begin
            bus.data_o <= is_mmio ? mmio_rdata : mem[ram_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gpio_sync1 <= '0;
         gpio_sync2 <= '0;
         gpio_out   <= '0;
      end else begin
         gpio_sync1 <= gpio_i;
         gpio_sync2 <= gpio_sync1;
         if (mmio_wr && reg_idx == 6'h00) begin
            gpio_out <= GPIO_W'(merge({{(32-GPIO_W){1'b0}}, gpio_out}, bus.data_i, bus.sel_i));
         end
      end
   end

   // A software COUNT write beats the increment; a new match beats W1C of pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         cmp     <= 32'hFFFF_FFFF;
         enable  <= 1'b0;
         pending <= 1'b0;
      end else begin
         if (mmio_wr && reg_idx == 6'h02) begin
            count <= merge(count, bus.data_i, bus.sel_i);
         end else if (match) begin
            count <= '0;
         end else if (enable) begin
            count <= count + 32'd1;
         end
         if (mmio_wr && reg_idx == 6'h03) begin
            cmp <= merge(cmp, bus.data_i, bus.sel_i);
         end
         if (mmio_wr && reg_idx == 6'h04 && bus.sel_i[0]) begin
            enable <= bus.data_i[0];
         end
         pending <= match || (pending && !pending_clr);
      end
   end

   assign gpio_o = gpio_out;
   assign irq_o  = pending;

endmodule
